pe_load_scheduler: RTL and testbench

Sequences one PE through a full processing pass.
- Streams weights (WEIGHT_PAR_WRITE words per beat) from a global-buffer source into the PE weight buffer.
- For each output window, streams input activations one word per beat into the PE iact buffer.
- Drains the resulting partial sums through psum_read_en / psum_out_valid.
- Sits between the global buffer / NoC source ports and one PE instance.
- Owns all of that PE's write enables and its psum read enable.

---
 rtl/pe_load_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_pe_load_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_load_scheduler.sv
// Sequences one PE through weight load, per-window iact load and psum drain.
// Optional psum watchdog enabled by defining PE_SCHED_TIMEOUT_EN.
module pe_load_scheduler #(
    parameter int DATA_WIDTH       = 16,
    parameter int MAX_CONFIG_WIDTH = 8,
    parameter int WEIGHT_PAR_WRITE = 4
`ifdef PE_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [MAX_CONFIG_WIDTH-1:0]            cfg_filter_size,
    input  logic [MAX_CONFIG_WIDTH-1:0]            cfg_input_channels_num,
    input  logic [MAX_CONFIG_WIDTH-1:0]            cfg_output_channels_num,
    input  logic [MAX_CONFIG_WIDTH-1:0]            cfg_num_windows,
    input  logic                                   src_weight_valid,
    output logic                                   src_weight_ready,
    input  logic [WEIGHT_PAR_WRITE*DATA_WIDTH-1:0] src_weight_data,
    input  logic                                   src_iact_valid,
    output logic                                   src_iact_ready,
    input  logic [DATA_WIDTH-1:0]                  src_iact_data,
    output logic                                   weight_write_en,
    output logic [WEIGHT_PAR_WRITE*DATA_WIDTH-1:0] data_weight_in,
    input  logic                                   weight_buffer_ready,
    output logic                                   iact_write_en,
    output logic [DATA_WIDTH-1:0]                  data_iact_in,
    input  logic                                   iact_buffer_ready,
    output logic                                   psum_read_en,
    input  logic                                   psum_out_valid,
    input  logic [DATA_WIDTH-1:0]                  data_psum_out,
    output logic                                   out_psum_valid,
    output logic [DATA_WIDTH-1:0]                  out_psum_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   cfg_error,
    output logic                                   timeout
);
    localparam int CW = MAX_CONFIG_WIDTH;
    localparam int PW = 3 * MAX_CONFIG_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_I, S_DRAIN, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [PW-1:0]   weight_beats_reg, beat_cnt_reg;
    logic [2*CW-1:0] iact_words_reg, iact_cnt_reg;
    logic [CW-1:0]   m_reg, w_reg, psum_cnt_reg, win_cnt_reg;
    logic            out_psum_valid_reg, cfg_error_reg, timeout_reg;
    logic [DATA_WIDTH-1:0] out_psum_data_reg;

    logic start_ok, start_bad, weight_fire, iact_fire, psum_fire;
    logic weight_last, iact_last, psum_last, win_more, cfg_zero;
    logic [PW-1:0]   wprod, weight_beats_calc;
    logic [PW:0]     wprod_round;
    logic [2*CW-1:0] iact_words_calc;

    assign cfg_zero = (cfg_filter_size == '0) || (cfg_input_channels_num == '0) ||
                      (cfg_output_channels_num == '0) || (cfg_num_windows == '0);
    assign wprod = PW'(cfg_filter_size) * PW'(cfg_input_channels_num) * PW'(cfg_output_channels_num);
    // One extra bit keeps the round-up addition from overflowing at the largest config.
    assign wprod_round       = (PW+1)'(wprod) + (PW+1)'(WEIGHT_PAR_WRITE - 1);
    assign weight_beats_calc = PW'(wprod_round / (PW+1)'(WEIGHT_PAR_WRITE));
    assign iact_words_calc   = (2*CW)'(cfg_filter_size) * (2*CW)'(cfg_input_channels_num);

    assign weight_last = (beat_cnt_reg == weight_beats_reg - PW'(1));
    assign iact_last   = (iact_cnt_reg == iact_words_reg - (2*CW)'(1));
    assign psum_last   = (psum_cnt_reg == m_reg - CW'(1));
    assign win_more    = (win_cnt_reg < w_reg - CW'(1));

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            wd_expire;
`endif

    always_comb begin
        state_next       = state_reg;
        start_ok         = 1'b0;
        start_bad        = 1'b0;
        src_weight_ready = 1'b0;
        src_iact_ready   = 1'b0;
        weight_fire      = 1'b0;
        iact_fire        = 1'b0;
        psum_fire        = 1'b0;
        psum_read_en     = 1'b0;
        done             = 1'b0;
`ifdef PE_SCHED_TIMEOUT_EN
        wd_expire        = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (cfg_zero) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                src_weight_ready = weight_buffer_ready;
                weight_fire      = src_weight_valid & weight_buffer_ready;
                if (weight_fire && weight_last) state_next = S_LOAD_I;
            end
            S_LOAD_I: begin
                src_iact_ready = iact_buffer_ready;
                iact_fire      = src_iact_valid & iact_buffer_ready;
                if (iact_fire && iact_last) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                psum_read_en = 1'b1;
                psum_fire    = psum_out_valid;
                if (psum_fire && psum_last) begin
                    state_next = win_more ? S_LOAD_I : S_DONE;
                end
`ifdef PE_SCHED_TIMEOUT_EN
                else if (!psum_out_valid && wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wd_expire  = 1'b1;
                    state_next = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign weight_write_en = weight_fire;
    assign iact_write_en   = iact_fire;
    assign busy            = (state_reg != S_IDLE);
    assign out_psum_valid  = out_psum_valid_reg;
    assign out_psum_data   = out_psum_data_reg;
    assign cfg_error       = cfg_error_reg;
    assign data_iact_in    = (state_reg == S_LOAD_I) ? src_iact_data : '0;

    // Weight lanes are passed through untouched (padding included) while loading.
    genvar gi;
    generate
        for (gi = 0; gi < WEIGHT_PAR_WRITE; gi++) begin : g_lane
            assign data_weight_in[gi*DATA_WIDTH +: DATA_WIDTH] =
                (state_reg == S_LOAD_W) ? src_weight_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_IDLE;
            weight_beats_reg   <= '0;
            iact_words_reg     <= '0;
            m_reg              <= '0;
            w_reg              <= '0;
            beat_cnt_reg       <= '0;
            iact_cnt_reg       <= '0;
            psum_cnt_reg       <= '0;
            win_cnt_reg        <= '0;
            out_psum_valid_reg <= 1'b0;
            out_psum_data_reg  <= '0;
            cfg_error_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cfg_error_reg      <= start_bad;
            out_psum_valid_reg <= psum_fire;
            if (psum_fire) out_psum_data_reg <= data_psum_out;
            if (start_ok) begin
                weight_beats_reg <= weight_beats_calc;
                iact_words_reg   <= iact_words_calc;
                m_reg            <= cfg_output_channels_num;
                w_reg            <= cfg_num_windows;
                beat_cnt_reg     <= '0;
                iact_cnt_reg     <= '0;
                psum_cnt_reg     <= '0;
                win_cnt_reg      <= '0;
            end
            if (weight_fire) beat_cnt_reg <= weight_last ? '0 : beat_cnt_reg + PW'(1);
            if (iact_fire) iact_cnt_reg <= iact_last ? '0 : iact_cnt_reg + (2*CW)'(1);
            if (psum_fire) begin
                if (psum_last) begin
                    psum_cnt_reg <= '0;
                    win_cnt_reg  <= win_more ? win_cnt_reg + CW'(1) : '0;
                end else begin
                    psum_cnt_reg <= psum_cnt_reg + CW'(1);
                end
            end
        end
    end

`ifdef PE_SCHED_TIMEOUT_EN
    // Watchdog restarts on DRAIN entry and on every psum the PE delivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= wd_expire;
            if (state_reg != S_DRAIN || psum_out_valid) wd_cnt_reg <= '0;
            else wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end
    end
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Directed self-checking bench for pe_load_scheduler: nominal, backpressure,
// padding, rejected start, mid-pass reset and (when enabled) the psum watchdog.
module tb_pe_load_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_f, cfg_c, cfg_m, cfg_w;
    logic        src_weight_valid, src_weight_ready;
    logic [63:0] src_weight_data;
    logic        src_iact_valid, src_iact_ready;
    logic [15:0] src_iact_data;
    logic        weight_write_en;
    logic [63:0] data_weight_in;
    logic        weight_buffer_ready;
    logic        iact_write_en;
    logic [15:0] data_iact_in;
    logic        iact_buffer_ready;
    logic        psum_read_en, psum_out_valid;
    logic [15:0] data_psum_out;
    logic        out_psum_valid;
    logic [15:0] out_psum_data;
    logic        busy, done, cfg_error, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pe_load_scheduler #(
        .DATA_WIDTH(16),
        .MAX_CONFIG_WIDTH(8),
        .WEIGHT_PAR_WRITE(4)
`ifdef PE_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_filter_size(cfg_f), .cfg_input_channels_num(cfg_c),
        .cfg_output_channels_num(cfg_m), .cfg_num_windows(cfg_w),
        .src_weight_valid(src_weight_valid), .src_weight_ready(src_weight_ready),
        .src_weight_data(src_weight_data),
        .src_iact_valid(src_iact_valid), .src_iact_ready(src_iact_ready),
        .src_iact_data(src_iact_data),
        .weight_write_en(weight_write_en), .data_weight_in(data_weight_in),
        .weight_buffer_ready(weight_buffer_ready),
        .iact_write_en(iact_write_en), .data_iact_in(data_iact_in),
        .iact_buffer_ready(iact_buffer_ready),
        .psum_read_en(psum_read_en), .psum_out_valid(psum_out_valid),
        .data_psum_out(data_psum_out),
        .out_psum_valid(out_psum_valid), .out_psum_data(out_psum_data),
        .busy(busy), .done(done), .cfg_error(cfg_error), .timeout(timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] wbeat(input int idx);
        logic [63:0] d;
        for (int l = 0; l < 4; l++) d[l*16 +: 16] = 16'h3000 + 16'(idx * 4 + l);
        return d;
    endfunction

    // Every outward strobe and data port at once; must be all zero when idle/reset.
    function automatic logic [63:0] outs_or();
        return {48'd0, out_psum_data} | {56'd0, src_weight_ready, src_iact_ready,
                weight_write_en, iact_write_en, psum_read_en, out_psum_valid, busy, done}
                | {62'd0, cfg_error, timeout} | data_weight_in | {48'd0, data_iact_in};
    endfunction

    // One pass: mode 1 adds weight-buffer and iact-source backpressure.
    // abort_at >= 0 returns right after that many iact writes were seen.
    task automatic run_pass(input int f, input int c, input int m, input int w,
                            input int exp_w, input int exp_i, input int exp_p,
                            input int mode, input int abort_at);
        int w_idx = 0, i_idx = 0, p_drv = 0, p_out = 0, done_cnt = 0, cyc = 0;
        bit prev_fire = 0, done_seen = 0;
        forever begin
            @(posedge clk); #1;
            start = !done_seen;
            cfg_f = (cyc == 0) ? 8'(f) : 8'd1;
            cfg_c = (cyc == 0) ? 8'(c) : 8'd1;
            cfg_m = (cyc == 0) ? 8'(m) : 8'd1;
            cfg_w = (cyc == 0) ? 8'(w) : 8'd1;
            src_weight_valid    = 1'b1;
            weight_buffer_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            src_weight_data     = wbeat(w_idx);
            src_iact_valid      = (mode == 1) ? (cyc % 3 != 2) : 1'b1;
            iact_buffer_ready   = 1'b1;
            src_iact_data       = 16'h5000 + 16'(i_idx);
            psum_out_valid      = 1'b1;
            data_psum_out       = 16'hA000 + 16'(p_drv);
            @(negedge clk);
            if (prev_fire) begin
                check_eq("psum_strobe", out_psum_valid, 1);
                check_eq("psum_data", out_psum_data, 16'hA000 + 16'(p_out));
                p_out++;
            end else if (out_psum_valid) begin
                check_eq("psum_spurious", out_psum_valid, 0);
            end
            prev_fire = psum_read_en & psum_out_valid;
            if (psum_read_en && psum_out_valid) begin
                check_eq("psum_after_iact", i_idx, f * c * (p_drv / m + 1));
                p_drv++;
            end
            if (weight_write_en) begin
                check_eq("w_handshake", {src_weight_valid, weight_buffer_ready, src_weight_ready}, 3'b111);
                check_eq("w_data", data_weight_in, wbeat(w_idx));
                check_eq("w_before_iact", i_idx, 0);
                w_idx++;
            end
            if (iact_write_en) begin
                check_eq("i_handshake", {src_iact_valid, iact_buffer_ready, src_iact_ready}, 3'b111);
                check_eq("i_data", data_iact_in, 16'h5000 + 16'(i_idx));
                check_eq("i_after_w", w_idx, exp_w);
                i_idx++;
            end
            if (done_seen) begin
                check_eq("busy_after_done", {busy, done}, 2'b00);
                break;
            end
            if (done) begin
                done_seen = 1;
                done_cnt++;
            end
            if (abort_at >= 0 && i_idx == abort_at) break;
            cyc++;
            if (cyc >= 600) begin
                check_eq("pass_cycle_budget", cyc, 0);
                break;
            end
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            check_eq("abort_w_count", w_idx, exp_w);
            check_eq("abort_done_count", done_cnt, 0);
        end else begin
            check_eq("w_count", w_idx, exp_w);
            check_eq("i_count", i_idx, exp_i);
            check_eq("psum_count", p_out, exp_p);
            check_eq("done_count", done_cnt, 1);
        end
        $display("pass F=%0d C=%0d M=%0d W=%0d mode=%0d: w=%0d i=%0d psum=%0d done=%0d",
                 f, c, m, w, mode, w_idx, i_idx, p_out, done_cnt);
    endtask

    initial begin
        int err_cnt, busy_seen, en_seen;
        rst = 1'b1; start = 1'b0;
        cfg_f = 8'd4; cfg_c = 8'd3; cfg_m = 8'd3; cfg_w = 8'd2;
        src_weight_valid = 1'b1; weight_buffer_ready = 1'b1; src_weight_data = 64'h1;
        src_iact_valid = 1'b1; iact_buffer_ready = 1'b1; src_iact_data = 16'h1;
        psum_out_valid = 1'b1; data_psum_out = 16'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", outs_or(), 0);
        $display("reset: outputs or-reduced=%0h", outs_or());
        @(posedge clk); #1 rst = 1'b0;

        run_pass(4, 3, 3, 2, 9, 24, 6, 0, -1);
        run_pass(4, 3, 3, 2, 9, 24, 6, 1, -1);
        run_pass(3, 1, 1, 1, 1, 3, 1, 0, -1);

        // Rejected start: zero output channels.
        err_cnt = 0; busy_seen = 0; en_seen = 0;
        @(posedge clk); #1;
        cfg_f = 8'd4; cfg_c = 8'd3; cfg_m = 8'd0; cfg_w = 8'd2; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            err_cnt   += int'(cfg_error);
            busy_seen += int'(busy);
            en_seen   += int'(weight_write_en | iact_write_en | psum_read_en |
                              src_weight_ready | src_iact_ready);
            if (k == 1) check_eq("cfg_error_timing", cfg_error, 1);
            @(posedge clk); #1 start = 1'b0;
        end
        check_eq("cfg_error_count", err_cnt, 1);
        check_eq("cfg_error_busy", busy_seen, 0);
        check_eq("cfg_error_enables", en_seen, 0);
        $display("rejected start: cfg_error=%0d busy=%0d enables=%0d", err_cnt, busy_seen, en_seen);

        // Reset in LOAD_I after 5 iact writes, then a clean pass.
        run_pass(4, 3, 3, 2, 9, 24, 6, 0, 5);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_outputs", outs_or(), 0);
        $display("mid-pass reset: outputs or-reduced=%0h", outs_or());
        run_pass(4, 3, 3, 2, 9, 24, 6, 0, -1);

`ifdef PE_SCHED_TIMEOUT_EN
        begin
            int drain_cycles = 0, to_seen = 0, done_seen2 = 0;
            @(posedge clk); #1;
            cfg_f = 8'd1; cfg_c = 8'd1; cfg_m = 8'd1; cfg_w = 8'd1; start = 1'b1;
            psum_out_valid = 1'b0;
            for (int k = 0; k < 60 && to_seen == 0; k++) begin
                @(negedge clk);
                drain_cycles += int'(psum_read_en);
                done_seen2   += int'(done);
                if (timeout) begin
                    to_seen = 1;
                    check_eq("timeout_busy", busy, 0);
                end
                @(posedge clk); #1 start = 1'b0;
            end
            check_eq("timeout_seen", to_seen, 1);
            check_eq("timeout_drain_cycles", drain_cycles, 16);
            check_eq("timeout_no_done", done_seen2, 0);
            @(negedge clk);
            check_eq("timeout_pulse_width", timeout, 0);
            $display("watchdog: drain_cycles=%0d timeout=%0d done=%0d", drain_cycles, to_seen, done_seen2);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
